prog_loader: RTL and testbench

Byte-serial program loader: the write side of the program memory that `rom` and `pcounter` read. It accepts a framed byte stream, assembles 14-bit opcodes and writes them sequentially into program memory from address 0. It holds the CPU (`clocks`, `pcounter` and the pipeline) in reset via `cpu_hold` until a complete frame with a valid checksum has been written. It sits between the external download port and the program-memory write port.

---
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader.sv | 154 +++++++++++++++
 tb/tb_prog_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Download byte stream and program-memory write port of the program loader.
// master = download/memory side, slave = loader.
interface prog_loader_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 14
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, prog_we, prog_addr, prog_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/prog_loader.sv
// Byte-serial program loader: parses SYNC/count/words/checksum frames, writes
// opcodes from address 0 and releases cpu_hold only after a good checksum.
module prog_loader #(
    parameter int         ADDR_W = 11,
    parameter int         DATA_W = 14,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);
    typedef enum logic [3:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_W_HI, S_W_LO, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam logic [11:0] N_MAX = 12'(1 << ADDR_W);

    state_t            state_reg;
    logic [2:0]        cnt_hi_reg;
    logic [5:0]        w_hi_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [11:0]       remain_reg;
    logic [7:0]        sum_reg;
    logic              prog_we_reg;
    logic [ADDR_W-1:0] prog_addr_reg;
    logic [DATA_W-1:0] prog_data_reg;
    logic              cpu_hold_reg;
    logic              done_reg;
    logic              error_reg;

    logic        take;
    logic [7:0]  sum_next;
    logic [11:0] n_words;

    assign bus.in_ready = (state_reg != S_WRITE) && (state_reg != S_DONE);
    assign take         = bus.in_valid && bus.in_ready;
    assign sum_next     = sum_reg + bus.in_data;
    assign n_words      = {1'b0, cnt_hi_reg, bus.in_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            cnt_hi_reg    <= '0;
            w_hi_reg      <= '0;
            addr_reg      <= '0;
            remain_reg    <= '0;
            sum_reg       <= '0;
            prog_we_reg   <= 1'b0;
            prog_addr_reg <= '0;
            prog_data_reg <= '0;
            cpu_hold_reg  <= 1'b1;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            prog_we_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (take && bus.in_data == SYNC) begin
                        sum_reg   <= '0;
                        state_reg <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (take) begin
                        sum_reg <= sum_next;
                        if (bus.in_data[7:3] != 5'd0) begin
                            error_reg <= 1'b1;
                            state_reg <= S_ERR;
                        end else begin
                            cnt_hi_reg <= bus.in_data[2:0];
                            state_reg  <= S_CNT_LO;
                        end
                    end
                end
                S_CNT_LO: begin
                    if (take) begin
                        sum_reg <= sum_next;
                        if (n_words == 12'd0) begin
                            state_reg <= S_CHK;
                        end else if (n_words > N_MAX) begin
                            error_reg <= 1'b1;
                            state_reg <= S_ERR;
                        end else begin
                            addr_reg   <= '0;
                            remain_reg <= n_words;
                            state_reg  <= S_W_HI;
                        end
                    end
                end
                S_W_HI: begin
                    if (take) begin
                        sum_reg <= sum_next;
                        if (bus.in_data[7:6] != 2'd0) begin
                            error_reg <= 1'b1;
                            state_reg <= S_ERR;
                        end else begin
                            w_hi_reg  <= bus.in_data[5:0];
                            state_reg <= S_W_LO;
                        end
                    end
                end
                S_W_LO: begin
                    // Strobe and payload are registered here so they are valid during WRITE.
                    if (take) begin
                        sum_reg       <= sum_next;
                        prog_we_reg   <= 1'b1;
                        prog_addr_reg <= addr_reg;
                        prog_data_reg <= DATA_W'({w_hi_reg, bus.in_data});
                        state_reg     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr_reg   <= addr_reg + 1'b1;
                    remain_reg <= remain_reg - 12'd1;
                    state_reg  <= (remain_reg == 12'd1) ? S_CHK : S_W_HI;
                end
                S_CHK: begin
                    if (take) begin
                        sum_reg <= sum_next;
                        if (sum_next == 8'd0) begin
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                            state_reg    <= S_DONE;
                        end else begin
                            error_reg <= 1'b1;
                            state_reg <= S_ERR;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_DONE;
                end
                S_ERR: begin
                    if (take && bus.in_data == SYNC) begin
                        error_reg <= 1'b0;
                        sum_reg   <= '0;
                        state_reg <= S_CNT_HI;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.prog_we   = prog_we_reg;
    assign bus.prog_addr = prog_addr_reg;
    assign bus.prog_data = prog_data_reg;
    assign cpu_hold      = cpu_hold_reg;
    assign done          = done_reg;
    assign error         = error_reg;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: byte-position frame model compared every
// cycle, plus literal frames and randomized frames with corruption and gaps.
module tb_prog_loader;
    localparam int         ADDR_W = 11;
    localparam int         DATA_W = 14;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic cpu_hold, done, error;

    prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC(SYNC)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: frame position counted in bytes since SYNC.
    bit          m_synced, m_done, m_err, m_we, m_ready, take;
    int          m_pos, m_n;
    logic [7:0]  m_hi, m_whi, m_sum;
    logic [10:0] m_addr;
    logic [13:0] m_data;

    logic [10:0] log_addr[$];
    logic [13:0] log_data[$];
    logic [7:0]  fq[$];

    function automatic void model_reset();
        m_synced = 0; m_pos = 0; m_n = 0; m_sum = 0; m_hi = 0; m_whi = 0;
        m_done = 0; m_err = 0; m_we = 0; m_addr = 0; m_data = 0; m_ready = 1;
    endfunction

    function automatic void model_fail();
        m_err = 1;
        m_synced = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (!m_synced) begin
            if (b == SYNC) begin
                m_synced = 1; m_pos = 0; m_sum = 0; m_err = 0;
            end
            return;
        end
        m_sum = m_sum + b;
        if (m_pos == 0) begin
            if (b[7:3] != 5'd0) begin model_fail(); return; end
            m_hi = b;
        end else if (m_pos == 1) begin
            m_n = int'({m_hi[2:0], b});
        end else if (m_pos < 2 * m_n + 2) begin
            if ((m_pos % 2) == 0) begin
                if (b[7:6] != 2'd0) begin model_fail(); return; end
                m_whi = b;
            end else begin
                m_we   = 1;
                m_addr = 11'((m_pos - 3) / 2);
                m_data = {m_whi[5:0], b};
            end
        end else begin
            if (m_sum == 8'd0) begin m_done = 1; m_synced = 0; end
            else model_fail();
        end
        m_pos++;
    endfunction

    initial begin : compare_proc
        logic [29:0] exp_v, got_v;
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_reset();
            end else begin
                take = m_ready && bus.in_valid;
                m_we = 0;
                if (take) model_byte(bus.in_data);
                m_ready = !m_we && !m_done;
            end
            #1;
            exp_v = {m_ready, m_we, m_addr, m_data, !m_done, m_done, m_err};
            got_v = {bus.in_ready, bus.prog_we, bus.prog_addr, bus.prog_data, cpu_hold, done, error};
            n_vec++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle t=%0t got rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b want rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b",
                         $time, bus.in_ready, bus.prog_we, bus.prog_addr, bus.prog_data, cpu_hold, done, error,
                         m_ready, m_we, m_addr, m_data, !m_done, m_done, m_err);
            end
            if (bus.prog_we === 1'b1) begin
                log_addr.push_back(bus.prog_addr);
                log_data.push_back(bus.prog_data);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
        $display("check %s got=%h want=%h", name, got, want);
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int t;
        if (m_done) return;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout byte=%h got ready=%b want 1", b, bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        if (gap) @(negedge clk);
    endtask

    task automatic send_frame(input bit gap);
        foreach (fq[i]) send(fq[i], gap);
        repeat (2) @(negedge clk);
    endtask

    task automatic build_frame(input int n);
        logic [7:0] s;
        fq = {};
        fq.push_back(SYNC);
        fq.push_back(8'(n >> 8));
        fq.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            fq.push_back(8'($urandom_range(0, 63)));
            fq.push_back(8'($urandom));
        end
        s = 8'd0;
        for (int k = 1; k < fq.size(); k++) s = s + fq[k];
        fq.push_back(8'd0 - s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        log_addr = {};
        log_data = {};
        @(negedge clk);
    endtask

    initial begin : stim
        logic [10:0] ref_addr[$];
        logic [13:0] ref_data[$];
        logic [2:0]  ref_flags;
        int          mode, n;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_lit("reset_ready", 32'(bus.in_ready), 32'd1);
        check_lit("reset_we",    32'(bus.prog_we),  32'd0);
        check_lit("reset_hold",  32'(cpu_hold),     32'd1);
        check_lit("reset_flags", {30'd0, done, error}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Leading garbage then a good two-word frame.
        send(8'h12, 0); send(8'h34, 0);
        check_lit("garbage_ready", 32'(bus.in_ready), 32'd1);
        fq = '{8'hA5, 8'h00, 8'h02, 8'h3F, 8'hFF, 8'h00, 8'h01, 8'hBF};
        send_frame(0);
        check_lit("good_nwrites", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() >= 2) begin
            check_lit("good_w0", {log_addr[0], 7'd0, log_data[0]}, {11'd0, 7'd0, 14'h3FFF});
            check_lit("good_w1", {log_addr[1], 7'd0, log_data[1]}, {11'd1, 7'd0, 14'h0001});
        end
        check_lit("good_final", {29'd0, done, cpu_hold, bus.in_ready}, 32'b100);

        // Empty frame.
        do_reset();
        fq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        check_lit("empty_nwrites", 32'(log_addr.size()), 32'd0);
        check_lit("empty_done", 32'(done), 32'd1);

        // Bad checksum, then recovery with a good frame.
        do_reset();
        fq = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h05, 8'h00};
        send_frame(0);
        check_lit("badchk_nwrites", 32'(log_addr.size()), 32'd1);
        if (log_addr.size() >= 1)
            check_lit("badchk_w0", {log_addr[0], 7'd0, log_data[0]}, {11'd0, 7'd0, 14'h0005});
        check_lit("badchk_flags", {29'd0, error, cpu_hold, done}, 32'b110);
        build_frame(2);
        send_frame(0);
        check_lit("recover_flags", {30'd0, done, error}, 32'b10);

        // Illegal W_HI and CNT_HI.
        do_reset();
        fq = '{8'hA5, 8'h00, 8'h01, 8'h40};
        send_frame(0);
        check_lit("bad_whi_err", {30'd0, error, bus.prog_we}, 32'b10);
        check_lit("bad_whi_nwrites", 32'(log_addr.size()), 32'd0);
        fq = '{8'hA5, 8'h08};
        send_frame(0);
        check_lit("bad_cnthi_err", {30'd0, error, cpu_hold}, 32'b11);

        // Back-to-back versus in_valid toggling.
        do_reset();
        build_frame(3);
        send_frame(0);
        ref_addr  = log_addr;
        ref_data  = log_data;
        ref_flags = {done, error, cpu_hold};
        do_reset();
        send_frame(1);
        check_lit("toggle_nwrites", 32'(log_addr.size()), 32'(ref_addr.size()));
        for (int k = 0; k < ref_addr.size() && k < log_addr.size(); k++)
            check_lit("toggle_word", {log_addr[k], 7'd0, log_data[k]}, {ref_addr[k], 7'd0, ref_data[k]});
        check_lit("toggle_flags", {29'd0, done, error, cpu_hold}, {29'd0, ref_flags});

        // Reset while in W_LO of word 1, then a fresh load.
        do_reset();
        fq = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h2A};
        foreach (fq[i]) send(fq[i], 0);
        check_lit("pre_rst_data", 32'(bus.prog_data), 32'h1234);
        reset = 1'b0;
        #1;
        check_lit("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        check_lit("mid_rst_bus", {bus.prog_we, bus.prog_addr, 6'd0, bus.prog_data}, 32'd0);
        check_lit("mid_rst_flags", {29'd0, cpu_hold, done, error}, 32'b100);
        @(negedge clk);
        reset = 1'b1;
        log_addr = {};
        log_data = {};
        @(negedge clk);
        build_frame(2);
        send_frame(0);
        check_lit("fresh_nwrites", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() >= 2)
            check_lit("fresh_addrs", {10'd0, log_addr[0], log_addr[1]}, {10'd0, 11'd0, 11'd1});
        check_lit("fresh_done", 32'(done), 32'd1);

        // Randomized frames with corruption, garbage and gaps.
        for (int it = 0; it < 40; it++) begin
            if (m_done || ($urandom_range(0, 3) == 0)) do_reset();
            repeat ($urandom_range(0, 2)) send(8'($urandom_range(0, 8'hA4)), 0);
            n = $urandom_range(0, 8);
            build_frame(n);
            mode = $urandom_range(0, 3);
            if (mode == 1) fq[fq.size() - 1] = fq[fq.size() - 1] ^ 8'h01;
            if (mode == 2 && n > 0) fq[3] = fq[3] | 8'h80;
            if (mode == 3) fq[1] = fq[1] | 8'h10;
            send_frame(1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
